// File: rtl/imem_loader.sv
// Program loader and instruction memory for the core. It assembles words from
// low/high chunk pairs, fills memory in order, then releases the core via run_o.
module imem_loader #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int CW    = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [CW-1:0]   chunk_i,
  input  logic            chunk_valid_i,
  input  logic [AW-1:0]   rd_addr_i,
  output logic [2*CW-1:0] rd_data_o,
  output logic            run_o,
  output logic            loading_o,
  output logic [AW-1:0]   wr_addr_o
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic [1:0] {LOAD_LO, LOAD_HI, RUN} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   lo_q;
  logic [AW-1:0]   wr_addr_q;
  logic            we;
  logic [2*CW-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD_LO;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD_LO: if (chunk_valid_i) state_nxt = LOAD_HI;
      LOAD_HI: if (chunk_valid_i) state_nxt = (wr_addr_q == LAST) ? RUN : LOAD_LO;
      RUN:     state_nxt = RUN;
      default: state_nxt = LOAD_LO;
    endcase
  end

  // Status outputs decode straight from state so they never glitch.
  always_comb begin
    we        = 1'b0;
    run_o     = 1'b0;
    loading_o = 1'b1;
    case (state)
      LOAD_HI: we = chunk_valid_i;
      RUN: begin
        run_o     = 1'b1;
        loading_o = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q      <= '0;
      wr_addr_q <= '0;
    end else begin
      if (state == LOAD_LO && chunk_valid_i) lo_q <= chunk_i;
      // The address parks on the last word so status shows DEPTH-1 during RUN.
      if (we && wr_addr_q != LAST) wr_addr_q <= wr_addr_q + 1'b1;
    end
  end

  // Memory has no reset; a complete reload overwrites every entry.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr_q] <= {chunk_i, lo_q};
  end

  assign wr_addr_o = wr_addr_q;
  assign rd_data_o = run_o ? mem[rd_addr_i] : '0;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus queues expected values, the
// monitor drains and compares them against the live DUT outputs.
module tb_imem_loader;
  localparam int DEPTH = 16, AW = 4, CW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CW-1:0] chunk_i = '0;
  logic          chunk_valid_i = 1'b0;
  logic [AW-1:0] rd_addr_i = '0;
  logic [11:0]   rd_data_o;
  logic          run_o, loading_o;
  logic [AW-1:0] wr_addr_o;

  imem_loader #(.DEPTH(DEPTH), .AW(AW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .chunk_i(chunk_i), .chunk_valid_i(chunk_valid_i),
    .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o), .run_o(run_o),
    .loading_o(loading_o), .wr_addr_o(wr_addr_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          sel;  // 0 rd_data, 1 run, 2 loading, 3 wr_addr
    logic [11:0] exp;
    int          tag;
  } item_t;

  item_t q[$];
  event  chk;
  int    total = 0, bad = 0;

  item_t       mit;
  logic [11:0] act;
  string       nm;

  initial forever begin
    @(chk);
    while (q.size() > 0) begin
      mit = q.pop_front();
      case (mit.sel)
        0:       begin act = rd_data_o;          nm = "rd_data"; end
        1:       begin act = {11'b0, run_o};     nm = "run";     end
        2:       begin act = {11'b0, loading_o}; nm = "loading"; end
        default: begin act = {8'b0, wr_addr_o};  nm = "wr_addr"; end
      endcase
      total++;
      if (act !== mit.exp) begin
        bad++;
        $display("FAIL %s tag=%0d got=%h want=%h", nm, mit.tag, act, mit.exp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic expect_(input int sel, input logic [11:0] e, input int tag);
    item_t it;
    it.sel = sel; it.exp = e; it.tag = tag;
    q.push_back(it);
  endtask

  task automatic flush();
    #1; ->chk; #1;
  endtask

  task automatic send(input logic [CW-1:0] c, input logic v);
    @(negedge clk);
    chunk_i = c; chunk_valid_i = v;
    @(posedge clk); #1;
  endtask

  task automatic reset_check(input int tag);
    rst_n = 1'b0; chunk_valid_i = 1'b0;
    #1;
    expect_(1, 12'h0, tag); expect_(2, 12'h1, tag);
    expect_(3, 12'h0, tag); expect_(0, 12'h0, tag);
    flush();
  endtask

  task automatic release_rst();
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  task automatic step(input int e, input int fin, input bit sweep, input int tag);
    if (sweep && e < fin) rd_addr_i = 4'(e % 16);
    expect_(1, 12'(e == fin), tag + e);
    if (sweep && e < fin) begin
      expect_(0, 12'h0, tag + e);
      expect_(2, 12'h1, tag + e);
      expect_(3, 12'(e / 2), tag + e);
    end
    flush();
  endtask

  task automatic load(input logic [CW-1:0] ch[32], input int gap5, input int gap9,
                      input bit sweep, input int tag);
    int e, fin;
    e = 0; fin = 32 + gap5 + gap9;
    for (int k = 0; k < 16; k++) begin
      if (k == 9)
        for (int g = 0; g < gap9; g++) begin send(6'h2A, 1'b0); e++; step(e, fin, sweep, tag); end
      send(ch[2*k], 1'b1); e++; step(e, fin, sweep, tag);
      if (k == 5)
        for (int g = 0; g < gap5; g++) begin send(6'h15, 1'b0); e++; step(e, fin, sweep, tag); end
      send(ch[2*k+1], 1'b1); e++; step(e, fin, sweep, tag);
    end
  endtask

  task automatic read_all(input logic [11:0] w[16], input int tag);
    for (int a = 15; a >= 0; a--) begin
      rd_addr_i = 4'(a);
      expect_(0, w[a], tag + a);
      flush();
    end
  endtask

  logic [CW-1:0] nom_ch[32], p100_ch[32], p240_ch[32];
  logic [11:0]   nom_w[16], p100_w[16], p240_w[16];

  initial begin
    // Nominal program; expected words are the hand-assembled {hi,lo} pairs.
    nom_ch = '{default: 6'h00};
    nom_ch[0] = 6'h04; nom_ch[1] = 6'h1E; nom_ch[2] = 6'h01; nom_ch[3] = 6'h1C;
    nom_ch[4] = 6'h18; nom_ch[5] = 6'h07; nom_ch[6] = 6'h10; nom_ch[7] = 6'h20;
    nom_w = '{default: 12'h000};
    nom_w[0] = 12'h784; nom_w[1] = 12'h701; nom_w[2] = 12'h1D8; nom_w[3] = 12'h810;
    // Word 0x100+k splits into lo=k, hi=0x04; word 0x240+k into lo=k, hi=0x09.
    for (int k = 0; k < 16; k++) begin
      p100_ch[2*k] = 6'(k); p100_ch[2*k+1] = 6'h04; p100_w[k] = 12'h100 + 12'(k);
      p240_ch[2*k] = 6'(k); p240_ch[2*k+1] = 6'h09; p240_w[k] = 12'h240 + 12'(k);
    end

    rd_addr_i = 4'd3;
    #2;
    reset_check(10);
    release_rst();

    load(nom_ch, 0, 0, 1'b1, 100);
    read_all(nom_w, 200);

    for (int i = 0; i < 10; i++) begin
      send(6'h3F, 1'b1);
      expect_(1, 12'h1, 300 + i); expect_(3, 12'hF, 300 + i);
      flush();
    end
    read_all(nom_w, 400);

    // Reset between edges during RUN
    rd_addr_i = 4'd0;
    @(posedge clk); #3;
    reset_check(500);
    release_rst();
    load(p240_ch, 3, 2, 1'b0, 600);
    read_all(p240_w, 700);

    // Reset right after the low chunk of word 7
    @(posedge clk); #3;
    reset_check(800);
    release_rst();
    for (int k = 0; k < 7; k++) begin
      send(6'h15, 1'b1); send(6'h2A, 1'b1);
    end
    send(6'h33, 1'b1);
    expect_(3, 12'h7, 850); expect_(1, 12'h0, 850);
    flush();
    reset_check(860);
    release_rst();
    load(p100_ch, 0, 0, 1'b0, 900);
    read_all(p100_w, 1000);

    flush();
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard leftover got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
